// File: rtl/count_loop_sequencer_if.sv
// Bundles the start/decode, count-register and data-memory signals of the
// count loop sequencer. The master modport is the sequencer itself; the slave
// modport is the surrounding decoder, count register and memory.
interface count_loop_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    // Decoder side
    logic                     start;
    logic [ADDR_W-1:0]        base_addr;
    logic [CNT_W-1:0]         length;

    // Count register side
    logic                     cnt_load;
    logic [CNT_W-1:0]         cnt_value;
    logic                     cnt_dec;
    logic                     cnt_nz;

    // Data memory side
    logic                     mem_rd;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_data;

    // Status and results
    logic                     busy;
    logic                     done;
    logic                     empty;
    logic [DATA_W-1:0]        max_out;
    logic [DATA_W-1:0]        min_out;
    logic [DATA_W+CNT_W-1:0]  sum_out;

    modport master (
        input  start, base_addr, length, cnt_nz, mem_data,
        output cnt_load, cnt_value, cnt_dec, mem_rd, mem_addr,
               busy, done, empty, max_out, min_out, sum_out
    );

    modport slave (
        output start, base_addr, length, cnt_nz, mem_data,
        input  cnt_load, cnt_value, cnt_dec, mem_rd, mem_addr,
               busy, done, empty, max_out, min_out, sum_out
    );
endinterface

// File: rtl/count_loop_sequencer.sv
// Count loop sequencer: loads the element-count register on start, then walks
// the data memory from base_addr, folding each word into running max/min/sum
// and decrementing the count once per element until the count register
// reports zero, then pulses done.
//
// Build option: define SEQ_SIGNED_EN to treat elements as two's-complement
// (signed max/min, sign-extended sum). Left undefined, elements are unsigned.
module count_loop_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    count_loop_sequencer_if.master bus
);

    localparam int SUM_W = DATA_W + CNT_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_ACC,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   max_q;
    logic [DATA_W-1:0]   max_nxt;
    logic [DATA_W-1:0]   min_q;
    logic [DATA_W-1:0]   min_nxt;
    logic [SUM_W-1:0]    sum_q;
    logic [SUM_W-1:0]    sum_nxt;
    logic                first_q;
    logic                first_nxt;
    logic                empty_q;
    logic                empty_nxt;

    logic                cnt_load_c;
    logic                cnt_dec_c;
    logic                mem_rd_c;

    logic [SUM_W-1:0]    elem_ext;
    logic                elem_gt;
    logic                elem_lt;

    // Element interpretation: the only place the signed build differs.
`ifdef SEQ_SIGNED_EN
    assign elem_ext = {{CNT_W{bus.mem_data[DATA_W-1]}}, bus.mem_data};
    assign elem_gt  = $signed(bus.mem_data) > $signed(max_q);
    assign elem_lt  = $signed(bus.mem_data) < $signed(min_q);
`else
    assign elem_ext = {{CNT_W{1'b0}}, bus.mem_data};
    assign elem_gt  = bus.mem_data > max_q;
    assign elem_lt  = bus.mem_data < min_q;
`endif

    // State register with synchronous reset to IDLE.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: address pointer, running results and flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr    <= '0;
            max_q   <= '0;
            min_q   <= '0;
            sum_q   <= '0;
            first_q <= 1'b0;
            empty_q <= 1'b0;
        end else begin
            addr    <= addr_nxt;
            max_q   <= max_nxt;
            min_q   <= min_nxt;
            sum_q   <= sum_nxt;
            first_q <= first_nxt;
            empty_q <= empty_nxt;
        end
    end

    // Next-state, datapath updates and strobes for each state.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves one unassigned, which would otherwise infer a latch.
        state_nxt  = state;
        addr_nxt   = addr;
        max_nxt    = max_q;
        min_nxt    = min_q;
        sum_nxt    = sum_q;
        first_nxt  = first_q;
        empty_nxt  = empty_q;
        cnt_load_c = 1'b0;
        cnt_dec_c  = 1'b0;
        mem_rd_c   = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.length != '0) begin
                        cnt_load_c = 1'b1;
                        addr_nxt   = bus.base_addr;
                        sum_nxt    = '0;
                        first_nxt  = 1'b1;
                        empty_nxt  = 1'b0;
                        state_nxt  = S_LOAD;
                    end else begin
                        max_nxt    = '0;
                        min_nxt    = '0;
                        sum_nxt    = '0;
                        empty_nxt  = 1'b1;
                        state_nxt  = S_DONE;
                    end
                end
            end

            // Gives the count register one cycle to publish cnt_nz for the load.
            S_LOAD: begin
                state_nxt = S_FETCH;
            end

            // Termination is decided by the count register alone.
            S_FETCH: begin
                if (bus.cnt_nz) begin
                    mem_rd_c  = 1'b1;
                    state_nxt = S_ACC;
                end else begin
                    state_nxt = S_DONE;
                end
            end

            // Read data is valid this cycle; fold it in and step the count.
            S_ACC: begin
                if (first_q || elem_gt) begin
                    max_nxt = bus.mem_data;
                end
                if (first_q || elem_lt) begin
                    min_nxt = bus.mem_data;
                end
                first_nxt = 1'b0;
                sum_nxt   = sum_q + elem_ext;
                cnt_dec_c = 1'b1;
                addr_nxt  = addr + ADDR_W'(1);
                state_nxt = S_FETCH;
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Strobes are suppressed while RESET is high so nothing leaks out of a
    // state that is about to be abandoned.
    assign bus.cnt_load  = cnt_load_c & ~RESET;
    assign bus.cnt_dec   = cnt_dec_c  & ~RESET;
    assign bus.mem_rd    = mem_rd_c   & ~RESET;
    assign bus.cnt_value = bus.cnt_load ? bus.length : '0;
    assign bus.mem_addr  = addr;

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.empty     = empty_q;
    assign bus.max_out   = max_q;
    assign bus.min_out   = min_q;
    assign bus.sum_out   = sum_q;

    // The three strobes never overlap.
    a_strobe_onehot: assert property (
        @(posedge CLK) disable iff (RESET)
        $onehot0({bus.cnt_load, bus.cnt_dec, bus.mem_rd})
    );

    // done is a single-cycle pulse.
    a_done_pulse: assert property (
        @(posedge CLK) disable iff (RESET)
        bus.done |=> !bus.done
    );

    // Every read is followed by its accumulate cycle.
    a_read_then_acc: assert property (
        @(posedge CLK) disable iff (RESET)
        bus.mem_rd |=> (state == S_ACC)
    );

endmodule

// File: tb/tb_count_loop_sequencer.sv
// Scoreboard bench for count_loop_sequencer. The driver computes each run's
// expected outcome from the memory contents with plain arithmetic and queues
// it; an independent monitor compares strobes and results as the DUT emits
// them. A behavioural count register and a one-cycle-latency memory close
// the loop around the DUT.
module tb_count_loop_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 8;

    typedef struct {
        logic [7:0]  max_v;
        logic [7:0]  min_v;
        logic [15:0] sum_v;
        logic        empty_v;
        int          n;
        int          done_cyc;
    } exp_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    count_loop_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    count_loop_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    exp_t        exp_q[$];
    logic [7:0]  addr_q[$];
    logic [7:0]  load_q[$];
    logic [7:0]  mem [256];
    logic [7:0]  cnt_reg = 8'd0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        expect_idle = 1'b0;
    logic        final_chk = 1'b0;

    // Cycle counter used to time done against the start cycle.
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural count register: registered, flag valid the cycle after.
    always @(posedge CLK) begin
        if (bus.cnt_load)     cnt_reg <= bus.cnt_value;
        else if (bus.cnt_dec) cnt_reg <= cnt_reg - 8'd1;
    end
    assign bus.cnt_nz = (cnt_reg != 8'd0);

    // Memory with data valid exactly one cycle after the read strobe.
    always @(posedge CLK) begin
        if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: fold the addressed elements with ordinary integers.
    function automatic exp_t model(input logic [7:0] base, input int n);
        exp_t e;
        int mx, mn, sm, v;
        logic [7:0] a;
        mx = 0; mn = 0; sm = 0; v = 0;
        for (int i = 0; i < n; i++) begin
            a = 8'(int'(base) + i);
`ifdef SEQ_SIGNED_EN
            v = int'($signed(mem[a]));
`else
            v = int'(mem[a]);
`endif
            if (i == 0 || v > mx) mx = v;
            if (i == 0 || v < mn) mn = v;
            sm += v;
        end
        e.max_v    = 8'(mx);
        e.min_v    = 8'(mn);
        e.sum_v    = 16'(sm);
        e.empty_v  = (n == 0);
        e.n        = n;
        e.done_cyc = 0;
        return e;
    endfunction

    // Monitor: compares everything the DUT presents against the queues.
    initial begin
        int   dec_cnt  = 0;
        int   load_cnt = 0;
        logic prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                check("strobes during reset",
                      {29'd0, bus.cnt_load, bus.cnt_dec, bus.mem_rd}, 32'd0);
                dec_cnt = 0; load_cnt = 0; prev_done = 1'b0;
            end else begin
                if (expect_idle) begin
                    check("idle busy/done/empty", {29'd0, bus.busy, bus.done, bus.empty}, 32'd0);
                    check("idle max/min", {16'd0, bus.max_out, bus.min_out}, 32'd0);
                    check("idle sum", 32'(bus.sum_out), 32'd0);
                    check("idle strobes", {29'd0, bus.cnt_load, bus.cnt_dec, bus.mem_rd}, 32'd0);
                end
                if (bus.cnt_load | bus.cnt_dec | bus.mem_rd)
                    check("strobes exclusive",
                          32'($countones({bus.cnt_load, bus.cnt_dec, bus.mem_rd})), 32'd1);
                if (bus.cnt_load) begin
                    load_cnt++;
                    check("cnt_load expected", 32'(load_q.size() > 0), 32'd1);
                    if (load_q.size() > 0) check("cnt_value", 32'(bus.cnt_value), 32'(load_q.pop_front()));
                end
                if (bus.mem_rd) begin
                    check("mem_rd expected", 32'(addr_q.size() > 0), 32'd1);
                    if (addr_q.size() > 0) check("mem_addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
                end
                if (bus.cnt_dec) dec_cnt++;
                if (prev_done) check("done single cycle, then idle", {30'd0, bus.done, bus.busy}, 32'd0);
                if (bus.done) begin
                    if (exp_q.size() == 0) begin
                        check("done with a run pending", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("done latency", 32'(cyc), 32'(e.done_cyc));
                        check("max_out", 32'(bus.max_out), 32'(e.max_v));
                        check("min_out", 32'(bus.min_out), 32'(e.min_v));
                        check("sum_out", 32'(bus.sum_out), 32'(e.sum_v));
                        check("empty", 32'(bus.empty), 32'(e.empty_v));
                        check("cnt_dec pulses", 32'(dec_cnt), 32'(e.n));
                        check("cnt_load pulses", 32'(load_cnt), 32'(e.n > 0));
                    end
                    dec_cnt = 0; load_cnt = 0;
                end
                prev_done = bus.done;
                if (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
                    check("done latency (no done seen)", 32'(cyc), 32'(exp_q[0].done_cyc));
                    void'(exp_q.pop_front());
                end
                if (final_chk)
                    check("queues drained", 32'(addr_q.size() + load_q.size() + exp_q.size()), 32'd0);
            end
        end
    end

    // All driver tasks start and end at #1 after a rising edge.
    task automatic wait_idle();
        for (int i = 0; i < 1000 && bus.busy; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() > 0; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic fill_rand(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) mem[8'(int'(base) + i)] = 8'($urandom);
    endtask

    // Queue expectations for a run and present the start pulse.
    task automatic launch(input logic [7:0] base, input int n, input logic expect_done);
        exp_t e;
        wait_idle();
        e = model(base, n);
        e.done_cyc = cyc + ((n == 0) ? 1 : 2 * n + 3);
        if (expect_done) exp_q.push_back(e);
        if (n > 0) load_q.push_back(8'(n));
        for (int i = 0; i < n && (expect_done || i < 2); i++) addr_q.push_back(8'(int'(base) + i));
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.length    = 8'(n);
        @(posedge CLK); #1;
        bus.start     = 1'b0;
        bus.base_addr = 8'($urandom);
        bus.length    = 8'($urandom);
    endtask

    task automatic run(input logic [7:0] base, input int n);
        launch(base, n, 1'b1);
        wait_drain(2 * n + 20);
    endtask

    // Keep start high with unrelated operands for the whole run.
    task automatic run_with_noise(input logic [7:0] base, input int n);
        launch(base, n, 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (bus.done) break;
            bus.start     = 1'b1;
            bus.base_addr = 8'($urandom);
            bus.length    = 8'($urandom_range(1, 255));
            @(posedge CLK); #1;
        end
        bus.start = 1'b0;
        wait_drain(2 * n + 20);
    endtask

    // Abort a length-5 run with RESET during its second accumulate cycle.
    task automatic run_reset(input logic [7:0] base);
        launch(base, 5, 1'b0);
        repeat (4) begin @(posedge CLK); #1; end
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        expect_idle = 1'b1;
        repeat (4) begin @(posedge CLK); #1; end
        expect_idle = 1'b0;
    endtask

    // Driver: directed cases first, then random runs.
    initial begin
        logic [7:0] base;
        bus.start = 1'b0; bus.base_addr = '0; bus.length = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        expect_idle = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
        expect_idle = 1'b0;

        run(8'h33, 0);

        mem[8'h10] = 8'd5; mem[8'h11] = 8'd200; mem[8'h12] = 8'd3; mem[8'h13] = 8'd17;
        run(8'h10, 4);

        fill_rand(8'hFE, 3);
        run(8'hFE, 3);

        for (int i = 0; i < 255; i++) mem[i] = 8'hFF;
        run(8'h00, 255);

        fill_rand(8'h40, 2);
        run_with_noise(8'h40, 2);
        fill_rand(8'h50, 3);
        run(8'h50, 3);

        fill_rand(8'h60, 5);
        run_reset(8'h60);
        fill_rand(8'h20, 2);
        run(8'h20, 2);

        mem[8'hA0] = 8'h80; mem[8'hA1] = 8'h7F; mem[8'hA2] = 8'hFF;
        run(8'hA0, 3);

        run(8'h77, 0);

        for (int r = 0; r < 10; r++) begin
            int n;
            base = 8'($urandom);
            n    = $urandom_range(0, 20);
            fill_rand(base, n);
            run(base, n);
        end

        wait_idle();
        final_chk = 1'b1;
        @(posedge CLK); #1;
        final_chk = 1'b0;
        @(posedge CLK); #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
